// File: rtl/dual_wr_queue.sv
// Two-port write front end: per-port FIFOs feeding a 2-write-port memory, with
// same-address collisions split over two cycles under alternating priority.
// Optional DUAL_WR_QUEUE_CONFLICT_CNT_EN adds an 8-bit saturating collision counter.
module dual_wr_queue #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in0_valid,
    output logic                       in0_ready,
    input  logic [ADDR_W-1:0]          in0_addr,
    input  logic [DATA_W-1:0]          in0_data,
    input  logic                       in1_valid,
    output logic                       in1_ready,
    input  logic [ADDR_W-1:0]          in1_addr,
    input  logic [DATA_W-1:0]          in1_data,
    output logic                       wr_en0,
    output logic [ADDR_W-1:0]          wr_addr0,
    output logic [DATA_W-1:0]          wr_data0,
    output logic                       wr_en1,
    output logic [ADDR_W-1:0]          wr_addr1,
    output logic [DATA_W-1:0]          wr_data1,
    output logic [$clog2(DEPTH):0]     q0_count,
    output logic [$clog2(DEPTH):0]     q1_count,
    output logic [7:0]                 conflict_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [1:0]    in_valid;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    head_valid;
    logic [EW-1:0] in_entry   [2];
    logic [EW-1:0] head_entry [2];
    logic [CW-1:0] count_reg  [2];
    logic          collide;
    logic          pri1_reg;

    assign in_valid    = {in1_valid, in0_valid};
    assign in_entry[0] = {in0_addr, in0_data};
    assign in_entry[1] = {in1_addr, in1_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [EW-1:0] mem [DEPTH];
            logic [PW-1:0] wptr_reg;
            logic [PW-1:0] rptr_reg;
            logic [CW-1:0] count_next;

            // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
            assign push[gi]       = in_valid[gi] & (count_reg[gi] != CW'(DEPTH));
            assign head_valid[gi] = (count_reg[gi] != '0);
            assign head_entry[gi] = mem[rptr_reg];

            always_comb begin
                count_next = count_reg[gi];
                case ({push[gi], pop[gi]})
                    2'b10:   count_next = count_reg[gi] + CW'(1);
                    2'b01:   count_next = count_reg[gi] - CW'(1);
                    default: count_next = count_reg[gi];
                endcase
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    wptr_reg      <= '0;
                    rptr_reg      <= '0;
                    count_reg[gi] <= '0;
                end else begin
                    if (push[gi]) wptr_reg <= wptr_reg + PW'(1);
                    if (pop[gi])  rptr_reg <= rptr_reg + PW'(1);
                    count_reg[gi] <= count_next;
                end
            end

            // Storage carries no reset; entries are only observed while the count says they are live.
            always_ff @(posedge clock) begin
                if (push[gi]) mem[wptr_reg] <= in_entry[gi];
            end
        end
    endgenerate

    always_comb begin
        collide = head_valid[0] & head_valid[1] &
                  (head_entry[0][EW-1:DATA_W] == head_entry[1][EW-1:DATA_W]);
        pop[0]  = head_valid[0] & ~(collide & pri1_reg);
        pop[1]  = head_valid[1] & ~(collide & ~pri1_reg);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       pri1_reg <= 1'b0;
        else if (collide) pri1_reg <= ~pri1_reg;
    end

`ifdef DUAL_WR_QUEUE_CONFLICT_CNT_EN
    logic [7:0] conflict_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                               conflict_reg <= 8'h00;
        else if (collide && conflict_reg != 8'hFF) conflict_reg <= conflict_reg + 8'h01;
    end

    assign conflict_cnt = conflict_reg;
`else
    assign conflict_cnt = 8'h00;
`endif

    assign in0_ready = (count_reg[0] != CW'(DEPTH));
    assign in1_ready = (count_reg[1] != CW'(DEPTH));
    assign q0_count  = count_reg[0];
    assign q1_count  = count_reg[1];
    assign wr_en0    = pop[0];
    assign wr_en1    = pop[1];
    assign wr_addr0  = head_entry[0][EW-1:DATA_W];
    assign wr_data0  = head_entry[0][DATA_W-1:0];
    assign wr_addr1  = head_entry[1][EW-1:DATA_W];
    assign wr_data1  = head_entry[1][DATA_W-1:0];
endmodule

// File: tb/tb_dual_wr_queue.sv
// Directed and randomized bench for dual_wr_queue against a queue-based reference model.
module tb_dual_wr_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } req_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in0_valid = 1'b0, in1_valid = 1'b0;
    logic       in0_ready, in1_ready;
    logic [3:0] in0_addr = '0, in1_addr = '0;
    logic [7:0] in0_data = '0, in1_data = '0;
    logic       wr_en0, wr_en1;
    logic [3:0] wr_addr0, wr_addr1;
    logic [7:0] wr_data0, wr_data1;
    logic [2:0] q0_count, q1_count;
    logic [7:0] conflict_cnt;

    dual_wr_queue #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_addr(in1_addr), .in1_data(in1_data),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .q0_count(q0_count), .q1_count(q1_count), .conflict_cnt(conflict_cnt)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    req_t mq0[$], mq1[$], src0[$], src1[$];
    bit   pri1 = 1'b0;
    int   ccnt = 0;
    bit   hold0 = 1'b0, hold1 = 1'b0;
    int   gap = 0;
    logic [7:0] mmem [16];
    logic [7:0] dmem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_conflict();
`ifdef DUAL_WR_QUEUE_CONFLICT_CNT_EN
        return ccnt;
`else
        return 0;
`endif
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step();
        bit r0, r1, h0, h1, coll, e0, e1;
        logic cw0, cw1;
        logic [3:0] ca0, ca1;
        logic [7:0] cd0, cd1;
        req_t r;
        r0 = (mq0.size() != DEPTH);
        r1 = (mq1.size() != DEPTH);
        in0_valid = (src0.size() > 0) && (hold0 || ($urandom_range(99) >= gap));
        in1_valid = (src1.size() > 0) && (hold1 || ($urandom_range(99) >= gap));
        if (in0_valid) begin in0_addr = src0[0].a; in0_data = src0[0].d; end
        else begin in0_addr = 4'($urandom); in0_data = 8'($urandom); end
        if (in1_valid) begin in1_addr = src1[0].a; in1_data = src1[0].d; end
        else begin in1_addr = 4'($urandom); in1_data = 8'($urandom); end
        #1;
        h0   = (mq0.size() > 0);
        h1   = (mq1.size() > 0);
        coll = h0 && h1 && (mq0[0].a == mq1[0].a);
        e0   = h0 && !(coll && pri1);
        e1   = h1 && !(coll && !pri1);
        chk("in0_ready", 32'(in0_ready), 32'(r0));
        chk("in1_ready", 32'(in1_ready), 32'(r1));
        chk("q0_count", 32'(q0_count), 32'(mq0.size()));
        chk("q1_count", 32'(q1_count), 32'(mq1.size()));
        chk("wr_en0", 32'(wr_en0), 32'(e0));
        chk("wr_en1", 32'(wr_en1), 32'(e1));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_conflict()));
        if (e0) chk("wr0_addr_data", {20'd0, wr_addr0, wr_data0}, {20'd0, mq0[0].a, mq0[0].d});
        if (e1) chk("wr1_addr_data", {20'd0, wr_addr1, wr_data1}, {20'd0, mq1[0].a, mq1[0].d});
        if (wr_en0 === 1'b1 && wr_en1 === 1'b1)
            chk("distinct_addr", 32'(wr_addr0 != wr_addr1), 32'd1);
        cw0 = wr_en0; ca0 = wr_addr0; cd0 = wr_data0;
        cw1 = wr_en1; ca1 = wr_addr1; cd1 = wr_data1;
        @(posedge clock);
        if (e0) begin r = mq0.pop_front(); mmem[r.a] = r.d; end
        if (e1) begin r = mq1.pop_front(); mmem[r.a] = r.d; end
        if (coll) begin
            pri1 = !pri1;
            if (ccnt < 255) ccnt++;
        end
        if (in0_valid && r0) mq0.push_back(src0.pop_front());
        if (in1_valid && r1) mq1.push_back(src1.pop_front());
        hold0 = in0_valid && !r0;
        hold1 = in1_valid && !r1;
        if (cw0 === 1'b1) dmem[ca0] = cd0;
        if (cw1 === 1'b1) dmem[ca1] = cd1;
        @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while ((src0.size() + src1.size() + mq0.size() + mq1.size()) != 0 && n < 2000) begin
            step();
            n++;
        end
        chk("drain_in_time", 32'(n < 2000), 32'd1);
        step();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        #1;
        chk("rst_q0_count", 32'(q0_count), 32'd0);
        chk("rst_q1_count", 32'(q1_count), 32'd0);
        chk("rst_wr_en", {30'd0, wr_en1, wr_en0}, 32'd0);
        chk("rst_ready", {30'd0, in1_ready, in0_ready}, 32'd3);
        chk("rst_conflict", 32'(conflict_cnt), 32'd0);
        mq0.delete(); mq1.delete(); src0.delete(); src1.delete();
        pri1 = 1'b0; ccnt = 0; hold0 = 1'b0; hold1 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), 32'(dmem[i]), 32'(mmem[i]));
    endtask

    task automatic load(input int port, input int n, input int amax, input int afix);
        req_t r;
        for (int i = 0; i < n; i++) begin
            r.a = (afix >= 0) ? 4'(afix) : 4'($urandom_range(amax));
            r.d = 8'($urandom);
            if (port == 0) src0.push_back(r); else src1.push_back(r);
        end
    endtask

    initial begin
        req_t r;
        for (int i = 0; i < 16; i++) begin mmem[i] = 8'h00; dmem[i] = 8'h00; end
        @(negedge clock);
        do_reset();
        repeat (3) step();

        // single port stream, addr 1..4 data A1..A4
        for (int i = 1; i <= 4; i++) begin
            r.a = 4'(i); r.d = 8'(8'hA0 + i);
            src0.push_back(r);
        end
        drain();
        chk("single_mem1", 32'(dmem[1]), 32'hA1);
        chk("single_mem4", 32'(dmem[4]), 32'hA4);

        // collision from reset
        do_reset();
        r.a = 4'd5; r.d = 8'h11; src0.push_back(r);
        r.a = 4'd5; r.d = 8'h22; src1.push_back(r);
        drain();
        chk("collide_mem5", 32'(dmem[5]), 32'h22);

        // alternation on addr 7
        load(0, 3, 0, 7);
        load(1, 3, 0, 7);
        drain();

        // full FIFO on port 1 with repeated head collisions
        load(1, 5, 0, 3);
        load(0, 8, 0, 3);
        drain();
        check_mem();

        // randomized traffic over a small address range
        gap = 30;
        load(0, 150, 3, -1);
        load(1, 150, 3, -1);
        drain();
        check_mem();
        gap = 0;

        // reset mid-traffic
        load(0, 6, 0, 2);
        load(1, 6, 0, 2);
        repeat (4) step();
        do_reset();
        repeat (5) step();

        // counter saturation
        load(0, 160, 0, 9);
        load(1, 160, 0, 9);
        drain();
`ifdef DUAL_WR_QUEUE_CONFLICT_CNT_EN
        chk("sat_conflict", 32'(conflict_cnt), 32'd255);
`else
        chk("sat_conflict", 32'(conflict_cnt), 32'd0);
`endif
        check_mem();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
